// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART transmit FIFO slice:
//   - DEPTH_DEFAULT    : default FIFO byte capacity
//   - WAIT_ACT_TIMEOUT : cycles the feeder waits for the transmitter to go busy
//   - ST_*             : feeder FSM state encodings (also visible on o_State)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DEPTH_DEFAULT    = 16;
  localparam int WAIT_ACT_TIMEOUT = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_ACT  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;

endpackage

// File: rtl/uart_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_fifo_mem
// DEPTH x 8 circular byte buffer with AW-bit read/write pointers.
// Synchronous write, combinational read of the head entry.
// Ports:
//   i_Clock, i_Reset : clock, synchronous active-high reset
//   i_Push, i_Data   : store i_Data at the tail (caller guarantees room,
//                      or a same-cycle pop when full)
//   i_Pop            : advance the head (caller guarantees non-empty)
//   o_Head           : byte at the head, valid when o_Empty=0
//   o_Count          : bytes stored, 0..DEPTH
//   o_Full, o_Empty  : occupancy flags derived from o_Count
// -----------------------------------------------------------------------------
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic          i_Push,
  input  logic [7:0]    i_Data,
  input  logic          i_Pop,
  output logic [7:0]    o_Head,
  output logic [AW:0]   o_Count,
  output logic          o_Full,
  output logic          o_Empty
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Pointers wrap DEPTH-1 -> 0 naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_Push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (i_Pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (i_Push && !i_Pop)      count_d = count_q + 1'b1;
    else if (i_Pop && !i_Push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  // When full with a same-cycle pop, wr_ptr equals rd_ptr: the head is read
  // combinationally before this edge overwrites it.
  always_ff @(posedge i_Clock) begin
    if (i_Push && !i_Reset) mem_q[wr_ptr_q] <= i_Data;
  end

  assign o_Head  = mem_q[rd_ptr_q];
  assign o_Count = count_q;
  assign o_Full  = (count_q == FULL_COUNT);
  assign o_Empty = (count_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Byte FIFO feeding a downstream UART transmitter one byte at a time.
// Ports:
//   i_Clock, i_Reset        : clock, synchronous active-high reset
//   i_Wr_DV, i_Wr_Byte      : write strobe and byte
//   o_Full, o_Empty, o_Count: FIFO occupancy
//   o_Overflow              : sticky; set by a dropped write or by a byte lost
//                             because the transmitter never went busy
//   o_Tx_DV, o_Tx_Byte      : one-cycle start pulse and byte to the transmitter
//   i_Tx_Active, i_Tx_Done  : transmitter busy / frame complete
//   o_State                 : feeder FSM state (ST_* encodings)
// Handshake: a byte is popped only in IDLE when the FIFO is non-empty and the
// transmitter is idle; o_Tx_DV is high for exactly the ISSUE cycle, and the
// feeder then waits for i_Tx_Active, then i_Tx_Done, then one GAP cycle.
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic          i_Wr_DV,
  input  logic [7:0]    i_Wr_Byte,
  output logic          o_Full,
  output logic          o_Empty,
  output logic [AW:0]   o_Count,
  output logic          o_Overflow,
  output logic          o_Tx_DV,
  output logic [7:0]    o_Tx_Byte,
  input  logic          i_Tx_Active,
  input  logic          i_Tx_Done,
  output logic [2:0]    o_State
);

  logic [2:0] state_q, state_d;
  logic [1:0] timer_q, timer_d;
  logic       tx_dv_q, tx_dv_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       ovf_q, ovf_d;

  logic       full, empty, pop, push, drop;
  logic [7:0] head;

  // Empty comes from the registered count, so a byte written into an empty
  // FIFO cannot be popped in its write cycle.
  assign pop  = (state_q == ST_IDLE) && !empty && !i_Tx_Active;
  assign push = i_Wr_DV && (!full || pop);
  assign drop = i_Wr_DV && full && !pop;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Push  (push),
    .i_Data  (i_Wr_Byte),
    .i_Pop   (pop),
    .o_Head  (head),
    .o_Count (o_Count),
    .o_Full  (full),
    .o_Empty (empty)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    ovf_d     = ovf_q | drop;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d   = ST_ISSUE;
          tx_dv_d   = 1'b1;
          tx_byte_d = head;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_ACT;
        timer_d = '0;
      end
      ST_WAIT_ACT: begin
        if (i_Tx_Active) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q == 2'(WAIT_ACT_TIMEOUT - 1)) begin
          // Transmitter never took the byte; it is lost.
          state_d = ST_IDLE;
          ovf_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (i_Tx_Done) state_d = ST_GAP;
      end
      ST_GAP: begin
        // One cycle covers the transmitter's cleanup cycle, during which
        // i_Tx_Done may still be high.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_Full     = full;
  assign o_Empty    = empty;
  assign o_Overflow = ovf_q;
  assign o_Tx_DV    = tx_dv_q;
  assign o_Tx_Byte  = tx_byte_q;
  assign o_State    = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo (DEPTH=16). Expected bytes are pushed into
// exp_q when written; a monitor pops and compares on every o_Tx_DV. A
// downstream transmitter model answers o_Tx_DV with a 40-cycle busy window
// followed by a 2-cycle done pulse, or holds busy, or stays silent.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int MODE_AUTO   = 0;
  localparam int MODE_HOLD   = 1;
  localparam int MODE_SILENT = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       wr_dv;
  logic [7:0] wr_byte;
  logic       full, empty, ovf, tx_dv, tx_active, tx_done;
  logic [4:0] count;
  logic [7:0] tx_byte;
  logic [2:0] state;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(16)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Wr_DV     (wr_dv),
    .i_Wr_Byte   (wr_byte),
    .o_Full      (full),
    .o_Empty     (empty),
    .o_Count     (count),
    .o_Overflow  (ovf),
    .o_Tx_DV     (tx_dv),
    .o_Tx_Byte   (tx_byte),
    .i_Tx_Active (tx_active),
    .i_Tx_Done   (tx_done),
    .o_State     (state)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] exp_q[$];
  int         dv_times[$];
  int         ds_mode = MODE_SILENT;
  int         ds_phase = 0;
  int         last_act_cyc = 0;
  logic       prev_dv = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- downstream transmitter model ----------------
  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (ds_mode == MODE_HOLD) begin
        tx_active = 1'b1; tx_done = 1'b0; ds_phase = 0;
      end else if (ds_mode == MODE_SILENT) begin
        tx_active = 1'b0; tx_done = 1'b0; ds_phase = 0;
      end else begin
        if (ds_phase > 0) begin
          ds_phase++;
          tx_active = (ds_phase >= 2 && ds_phase <= 41);
          tx_done   = (ds_phase == 42 || ds_phase == 43);
          if (ds_phase == 43) ds_phase = 0;
        end else begin
          tx_active = 1'b0; tx_done = 1'b0;
        end
        if (tx_dv === 1'b1) ds_phase = 1;
      end
      if (tx_active) last_act_cyc = cyc;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    @(negedge clk);
    if (tx_dv === 1'b1) begin
      dv_times.push_back(cyc);
      check("tx_dv_one_cycle", {31'd0, prev_dv}, 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_dv_unexpected: got byte 0x%0h, required no pulse", tx_byte);
      end else begin
        check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_dv = tx_dv;
  end

  // ---------------- driver tasks ----------------
  task automatic write_byte(input logic [7:0] b, input bit accepted);
    @(posedge clk); #1;
    wr_dv   = 1'b1;
    wr_byte = b;
    if (accepted) exp_q.push_back(b);
  endtask

  task automatic end_write();
    @(posedge clk); #1;
    wr_dv = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic settle();
    for (int k = 0; k < 200 && ds_phase != 0; k++) @(posedge clk);
    check("ds_settle", ds_phase, 0);
  endtask

  task automatic wait_dv(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (tx_dv === 1'b1) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int dv_cyc;
    rst = 1'b1; wr_dv = 1'b0; wr_byte = 8'h00;

    // Reset state; a write during reset is ignored.
    @(posedge clk); #1;
    wr_dv = 1'b1; wr_byte = 8'hFF;
    @(posedge clk); #1;
    rst = 1'b0; wr_dv = 1'b0;
    @(negedge clk);
    check("rst_count",   count, 0);
    check("rst_empty",   empty, 1);
    check("rst_full",    full, 0);
    check("rst_ovf",     ovf, 0);
    check("rst_tx_dv",   tx_dv, 0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_state",   state, ST_IDLE);

    // Single byte: pulse two cycles after the write.
    ds_mode = MODE_AUTO;
    write_byte(8'hA5, 1);
    end_write();
    @(negedge clk);
    check("a5_count_after_write", count, 1);
    check("a5_no_dv_yet", tx_dv, 0);
    @(negedge clk);
    check("a5_tx_dv", tx_dv, 1);
    check("a5_tx_byte", tx_byte, 8'hA5);
    check("a5_empty_after_pop", empty, 1);
    check("a5_state_issue", state, ST_ISSUE);

    // Three bytes back-to-back: spacing = 40-cycle frame + 4.
    settle();
    do_reset();
    dv_times.delete();
    write_byte(8'h01, 1);
    write_byte(8'h02, 1);
    write_byte(8'h03, 1);
    end_write();
    for (int k = 0; k < 300 && dv_times.size() < 3; k++) @(posedge clk);
    check("b2b_pulses", dv_times.size(), 3);
    if (dv_times.size() >= 3) begin
      check("b2b_spacing_1", dv_times[1] - dv_times[0], 44);
      check("b2b_spacing_2", dv_times[2] - dv_times[1], 44);
    end
    repeat (5) @(negedge clk);
    check("b2b_byte_held", tx_byte, 8'h03);
    check("b2b_wait_done", state, ST_WAIT_DONE);

    // Fill to DEPTH with the transmitter held busy.
    settle();
    ds_mode = MODE_HOLD;
    do_reset();
    for (int i = 0; i < 16; i++) write_byte(8'(i + 1), 1);
    end_write();
    @(negedge clk);
    check("fill_count", count, 16);
    check("fill_full", full, 1);
    check("fill_ovf_clear", ovf, 0);
    // Write coinciding with a pop while full: accepted.
    @(posedge clk); #1;
    ds_mode = MODE_AUTO;
    wr_dv = 1'b1; wr_byte = 8'h11; exp_q.push_back(8'h11);
    @(posedge clk); #1;
    wr_byte = 8'h22;  // next write lands in ISSUE with no pop: dropped
    @(negedge clk);
    check("simul_count", count, 16);
    check("simul_full", full, 1);
    check("simul_ovf", ovf, 0);
    check("simul_state", state, ST_ISSUE);
    @(posedge clk); #1;
    wr_dv = 1'b0;
    @(negedge clk);
    check("drop_count", count, 16);
    check("drop_ovf", ovf, 1);
    for (int k = 0; k < 1500 && exp_q.size() != 0; k++) @(posedge clk);
    check("drain_done", exp_q.size(), 0);
    @(negedge clk);
    check("drain_empty", empty, 1);
    check("drain_ovf_sticky", ovf, 1);

    // Transmitter never goes busy: timeout after 4 cycles.
    settle();
    ds_mode = MODE_SILENT;
    do_reset();
    write_byte(8'h3C, 1);
    end_write();
    wait_dv("to_dv_seen");
    repeat (4) @(negedge clk);
    check("to_still_waiting", state, ST_WAIT_ACT);
    check("to_ovf_before", ovf, 0);
    @(negedge clk);
    check("to_state_idle", state, ST_IDLE);
    check("to_ovf_set", ovf, 1);

    // Reset during WAIT_DONE with 5 bytes queued.
    ds_mode = MODE_AUTO;
    do_reset();
    for (int i = 0; i < 6; i++) write_byte(8'hB0 + 8'(i), 1);
    end_write();
    for (int k = 0; k < 20 && state !== ST_WAIT_DONE; k++) @(negedge clk);
    check("mid_state_wait_done", state, ST_WAIT_DONE);
    check("mid_queued", count, 5);
    do_reset();
    @(negedge clk);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_state", state, ST_IDLE);
    check("mid_rst_ovf", ovf, 0);
    dv_times.delete();
    write_byte(8'h5A, 1);
    end_write();
    dv_cyc = -1;
    for (int k = 0; k < 100 && dv_cyc < 0; k++) begin
      @(negedge clk);
      if (tx_dv === 1'b1) dv_cyc = cyc;
    end
    check("mid_dv_seen", {31'd0, dv_cyc >= 0}, 32'd1);
    check("mid_no_issue_while_active", {31'd0, dv_cyc >= last_act_cyc + 2}, 32'd1);

    settle();
    check("final_exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO byte capacity; power of two, >= 2.
REQ-002 Parameter AW, default log2(DEPTH), FIFO address width; derived, not overridden.
REQ-003 i_Clock  in  1  sole clock; all logic on rising edge.
REQ-004 i_Reset  in  1  synchronous, active-high reset.
REQ-005 i_Wr_DV  in  1  write strobe; one byte per asserted cycle.
REQ-006 i_Wr_Byte  in  8  byte written when i_Wr_DV=1.
REQ-007 o_Full  out  1  FIFO holds DEPTH bytes.
REQ-008 o_Empty  out  1  FIFO holds 0 bytes.
REQ-009 o_Count  out  AW+1  bytes currently stored, 0..DEPTH.
REQ-010 o_Overflow  out  1  sticky flag: a write was dropped.
REQ-011 o_Tx_DV  out  1  one-cycle start pulse to the downstream UART transmitter.
REQ-012 o_Tx_Byte  out  8  byte for the downstream transmitter.
REQ-013 i_Tx_Active  in  1  downstream transmitter busy.
REQ-014 i_Tx_Done  in  1  downstream transmit complete; may stay high for 2 consecutive cycles.

Function
REQ-015 Storage SHALL be a circular buffer with AW-bit read/write pointers that wrap from DEPTH-1 to 0.
REQ-016 A write with o_Full=0 SHALL store the byte and update o_Count/o_Full/o_Empty on the next edge.
REQ-017 A write with o_Full=1 and no same-cycle pop SHALL be dropped and set o_Overflow the next cycle; o_Overflow holds until reset.
REQ-018 A simultaneous write and pop with o_Full=1 SHALL accept the write; o_Count stays DEPTH.
REQ-019 A simultaneous write and pop with 0<o_Count<DEPTH SHALL leave o_Count unchanged.
REQ-020 A write to an empty FIFO SHALL NOT be popped in the same cycle; the earliest o_Tx_DV is 2 cycles after the write.
REQ-021 The feeder FSM SHALL use the states IDLE, ISSUE, WAIT_ACT, WAIT_DONE and GAP.
REQ-022 IDLE -> ISSUE when o_Empty=0 and i_Tx_Active=0; the head byte is popped into o_Tx_Byte on this transition.
REQ-023 In ISSUE, o_Tx_DV SHALL be 1 for exactly one cycle; next state is WAIT_ACT.
REQ-024 WAIT_ACT -> WAIT_DONE on i_Tx_Active=1.
REQ-025 WAIT_ACT -> IDLE after 4 cycles without i_Tx_Active; the popped byte is lost and o_Overflow is set.
REQ-026 WAIT_DONE -> GAP on i_Tx_Done=1.
REQ-027 GAP SHALL last exactly 1 cycle, so the downstream cleanup/idle cycle is honoured; then -> IDLE.
REQ-028 The minimum o_Tx_DV spacing for back-to-back bytes SHALL therefore be (downstream frame length + 4) cycles.
REQ-029 o_Tx_Byte SHALL hold stable from the ISSUE cycle until the next pop.
REQ-030 o_Tx_DV SHALL never be asserted outside ISSUE.

Reset
REQ-031 On i_Reset=1 at an edge: pointers=0, o_Count=0, o_Empty=1, o_Full=0, o_Overflow=0, o_Tx_DV=0, o_Tx_Byte=8'h00, FSM=IDLE.
REQ-032 Writes in the reset cycle SHALL be ignored.
REQ-033 Reset mid-frame SHALL discard the FIFO contents; the downstream transmitter (unreset) finishes its byte.
REQ-034 No new issue SHALL occur until i_Tx_Active=0 (enforced by REQ-022).

Structure
REQ-035 A shared package uart_pkg SHALL hold the FSM state encodings, the DEPTH default and the WAIT_ACT timeout constant (4).
REQ-036 Storage and pointer logic SHALL be the sub-module uart_fifo_mem (DEPTH x 8, synchronous write, combinational head read).
REQ-037 uart_tx_fifo SHALL contain the FSM and the output register logic.

Verification
REQ-038 Reset, write 8'hA5 -> o_Tx_DV pulse 2 cycles later with o_Tx_Byte=8'hA5, o_Empty=1 after the pop.
REQ-039 Write 3 bytes (01,02,03) back-to-back against the real transmitter with CLKS_PER_BIT=4 -> serial frames in order; o_Tx_DV spacing = 40+4 cycles.
REQ-040 Write 17 bytes with DEPTH=16 and the downstream held active -> o_Full=1, o_Count=16, 17th byte dropped, o_Overflow=1.
REQ-041 With o_Full=1, write in the same cycle as a pop -> byte accepted, o_Count stays 16, o_Overflow unchanged.
REQ-042 Pulse i_Reset during WAIT_DONE with 5 bytes queued -> o_Count=0 next cycle; no o_Tx_DV until i_Tx_Active=0 and a new write occurs.
REQ-043 Hold i_Tx_Active=0 after o_Tx_DV -> return to IDLE after 4 cycles, o_Overflow=1.
